// File: rtl/threediff_in_cond.sv
// Input conditioning for threediff: 2-flop sync plus debounce (THREEDIFF_IN_DEBOUNCE_EN) on x, parity-checked serial key.
// Latency: x_out 2+DEB_CYCLES edges with debounce, 2 without; key applied one cycle after the parity bit.
// Backpressure: none; key_sin is taken only with key_sval, key_load is ignored while a frame is in flight.
module threediff_in_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int KEY_LEN    = 8,
    parameter int KEY_IDX    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] raw_x,
    input  logic        key_load,
    input  logic        key_sval,
    input  logic        key_sin,
    output logic [11:0] x_out,
    output logic        x_chg,
    output logic        keyinput0,
    output logic        key_ready,
    output logic        key_busy,
    output logic        key_err
);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 15) begin : g_bad_deb
        $error("threediff_in_cond: DEB_CYCLES must be 1..15");
    end
    if (KEY_LEN < 1 || KEY_LEN > 32) begin : g_bad_len
        $error("threediff_in_cond: KEY_LEN must be 1..32");
    end
    if (KEY_IDX < 0 || KEY_IDX >= KEY_LEN) begin : g_bad_idx
        $error("threediff_in_cond: KEY_IDX must be below KEY_LEN");
    end

    localparam int BW = $clog2(KEY_LEN + 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(KEY_LEN);

    typedef enum logic [1:0] {
        K_IDLE  = 2'd0,
        K_SHIFT = 2'd1,
        K_CHECK = 2'd2,
        K_DONE  = 2'd3
    } kstate_t;

    logic [11:0] s_meta;
    logic [11:0] x_nxt;

`ifdef THREEDIFF_IN_DEBOUNCE_EN
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    logic [11:0]      s_sync;
    logic [11:0][3:0] cnt;
    logic [11:0][3:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= '0;
            s_sync <= '0;
            cnt    <= '0;
        end else begin
            s_meta <= raw_x;
            s_sync <= s_meta;
            cnt    <= cnt_nxt;
        end
    end

    // A bit only moves after s_sync has disagreed with it for DEB_CYCLES consecutive cycles.
    always_comb begin
        x_nxt   = x_out;
        cnt_nxt = '0;
        for (int i = 0; i < 12; i++) begin
            if (s_sync[i] != x_out[i]) begin
                if (cnt[i] == DEB_LAST) begin
                    x_nxt[i] = s_sync[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 4'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= '0;
        end else begin
            s_meta <= raw_x;
        end
    end

    // Without debounce, x_out itself is the second synchroniser stage.
    always_comb begin
        x_nxt = s_meta;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out <= '0;
            x_chg <= 1'b0;
        end else begin
            x_out <= x_nxt;
            x_chg <= |(x_nxt ^ x_out);
        end
    end

    kstate_t          state;
    kstate_t          state_nxt;
    logic [BW-1:0]    bcnt;
    logic [BW-1:0]    bcnt_nxt;
    logic [KEY_LEN:0] sr;
    logic [KEY_LEN:0] sr_nxt;
    logic             key_nxt;
    logic             ready_nxt;
    logic             err_nxt;
    logic             busy_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= K_IDLE;
            bcnt      <= '0;
            sr        <= '0;
            keyinput0 <= 1'b0;
            key_ready <= 1'b0;
            key_busy  <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bcnt      <= bcnt_nxt;
            sr        <= sr_nxt;
            keyinput0 <= key_nxt;
            key_ready <= ready_nxt;
            key_busy  <= busy_nxt;
            key_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        sr_nxt    = sr;
        key_nxt   = keyinput0;
        ready_nxt = key_ready;
        err_nxt   = 1'b0;
        case (state)
            K_IDLE: begin
                if (key_load) begin
                    state_nxt = K_SHIFT;
                    bcnt_nxt  = '0;
                end
            end
            K_SHIFT: begin
                // Right shift so the first bit received ends up in sr[0].
                if (key_sval) begin
                    sr_nxt   = {key_sin, sr[KEY_LEN:1]};
                    bcnt_nxt = bcnt + BW'(1);
                    if (bcnt == LAST_BIT) begin
                        state_nxt = K_CHECK;
                    end
                end
            end
            K_CHECK: begin
                if (^sr == 1'b0) begin
                    key_nxt   = sr[KEY_IDX];
                    ready_nxt = 1'b1;
                    state_nxt = K_DONE;
                end else begin
                    err_nxt   = 1'b1;
                    ready_nxt = 1'b0;
                    state_nxt = K_IDLE;
                end
            end
            K_DONE: begin
                if (key_load) begin
                    state_nxt = K_SHIFT;
                    bcnt_nxt  = '0;
                    ready_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = K_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == K_SHIFT) || (state_nxt == K_CHECK);
    end

endmodule

// File: tb/tb_threediff_in_cond.sv
// Scoreboard bench for threediff_in_cond: stimulus pushes expected x_out / key results, a monitor pops on x_chg and key events.
module tb_threediff_in_cond;

`ifdef THREEDIFF_IN_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
    localparam int LAT    = 6;
`else
    localparam bit DEB_ON = 1'b0;
    localparam int LAT    = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] raw_x = '0;
    logic        key_load = 1'b0;
    logic        key_sval = 1'b0;
    logic        key_sin = 1'b0;
    logic [11:0] x_out;
    logic        x_chg;
    logic        keyinput0;
    logic        key_ready;
    logic        key_busy;
    logic        key_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] xq[$];
    logic [1:0]  kq[$];
    logic        ready_q = 1'b0;

    threediff_in_cond dut (
        .clk       (clk),
        .rst       (rst),
        .raw_x     (raw_x),
        .key_load  (key_load),
        .key_sval  (key_sval),
        .key_sin   (key_sin),
        .x_out     (x_out),
        .x_chg     (x_chg),
        .keyinput0 (keyinput0),
        .key_ready (key_ready),
        .key_busy  (key_busy),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every x_chg pulse and every key result is checked against the queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            ready_q = 1'b0;
        end else begin
            if (x_chg) begin
                if (xq.size() == 0) chk("x_event_unexpected", {20'd0, x_out}, 32'hFFFF_FFFF);
                else chk("x_event", {20'd0, x_out}, {20'd0, xq.pop_front()});
            end
            if (key_err || (key_ready && !ready_q)) begin
                if (kq.size() == 0) chk("key_event_unexpected", {30'd0, key_err, keyinput0}, 32'hFFFF_FFFF);
                else chk("key_event", {30'd0, key_err, keyinput0}, {30'd0, kq.pop_front()});
            end
            ready_q = key_ready;
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_bit3(input int len, output int hi, output int chg);
        hi  = 0;
        chg = 0;
        if (!DEB_ON || len >= DEB_ON * 4) begin
            xq.push_back(12'h008);
            xq.push_back(12'h000);
        end
        raw_x = 12'h008;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            hi  += int'(x_out[3]);
            chg += int'(x_chg);
        end
        raw_x = 12'h000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi  += int'(x_out[3]);
            chg += int'(x_chg);
        end
    endtask

    // fr = {parity, data[7:0]}, sent LSB first; gap idle cycles precede each bit.
    task automatic run_frame(input logic [8:0] fr, input int gap, input bit midload,
                             input bit exp_err, input bit exp_key);
        kq.push_back({exp_err, exp_key});
        key_load = 1'b1;
        key_sval = 1'b1;
        key_sin  = ~fr[0];
        @(negedge clk);
        key_load = 1'b0;
        key_sval = 1'b0;
        chk("busy_after_load", {31'd0, key_busy}, 32'd1);
        chk("ready_after_load", {31'd0, key_ready}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            for (int g = 0; g < gap; g++) begin
                key_load = midload && (i == 4) && (g == 0);
                @(negedge clk);
                key_load = 1'b0;
            end
            key_sval = 1'b1;
            key_sin  = fr[i];
            @(negedge clk);
            key_sval = 1'b0;
            if (i == 7) chk("not_done_after_8_bits", {30'd0, key_busy, key_ready}, 32'd2);
        end
        chk("busy_in_check", {31'd0, key_busy}, 32'd1);
        @(negedge clk);
        chk("busy_after_check", {31'd0, key_busy}, 32'd0);
        chk("ready_after_check", {31'd0, key_ready}, {31'd0, !exp_err});
        chk("key_after_check", {31'd0, keyinput0}, {31'd0, exp_key});
        chk("err_after_check", {31'd0, key_err}, {31'd0, exp_err});
        @(negedge clk);
        chk("err_one_cycle", {31'd0, key_err}, 32'd0);
    endtask

    initial begin
        int hi;
        int chg;
        cycles(3);
        chk("rst_x_out", {20'd0, x_out}, 32'd0);
        chk("rst_flags", {27'd0, x_chg, keyinput0, key_ready, key_busy, key_err}, 32'd0);
        rst = 1'b0;
        cycles(3);

        // Latency and single x_chg pulse for a stable pattern.
        raw_x = 12'hA5A;
        xq.push_back(12'hA5A);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("lat_x_out_e%0d", k), {20'd0, x_out}, (k >= LAT) ? 32'hA5A : 32'd0);
            chk($sformatf("lat_x_chg_e%0d", k), {31'd0, x_chg}, (k == LAT) ? 32'd1 : 32'd0);
        end
        raw_x = 12'h000;
        xq.push_back(12'h000);
        cycles(12);

        pulse_bit3(3, hi, chg);
        chk("glitch3_hi_cycles", hi, DEB_ON ? 32'd0 : 32'd3);
        chk("glitch3_chg_pulses", chg, DEB_ON ? 32'd0 : 32'd2);
        pulse_bit3(4, hi, chg);
        chk("glitch4_hi_cycles", hi, 32'd4);
        chk("glitch4_chg_pulses", chg, 32'd2);

        raw_x = 12'h5A5;
        xq.push_back(12'h5A5);
        cycles(10);
        chk("x_settled_5a5", {20'd0, x_out}, 32'h5A5);

        run_frame(9'b1_0000_0001, 0, 1'b0, 1'b0, 1'b1);
        run_frame(9'b0_0000_0001, 0, 1'b0, 1'b1, 1'b1);
        run_frame(9'b1_1111_1110, 5, 1'b1, 1'b0, 1'b0);
        run_frame(9'b1_0000_0001, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset after 4 of 9 frame bits.
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_sval = 1'b1;
            key_sin  = 1'b1;
            @(negedge clk);
            key_sval = 1'b0;
        end
        chk("busy_before_rst", {31'd0, key_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_x_out", {20'd0, x_out}, 32'd0);
        chk("async_rst_flags", {27'd0, x_chg, keyinput0, key_ready, key_busy, key_err}, 32'd0);
        cycles(2);
        rst = 1'b0;
        xq.push_back(12'h5A5);
        cycles(10);
        chk("x_after_rst", {20'd0, x_out}, 32'h5A5);
        run_frame(9'b1_0000_0001, 0, 1'b0, 1'b0, 1'b1);

        cycles(10);
        chk("xq_drained", xq.size(), 32'd0);
        chk("kq_drained", kq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
